// File: rtl/sprot_protocol_checker.sv
// rtl/sprot_protocol_checker.sv - multi-channel sprot valid/ready protocol monitor
// Optional feature: define SPROT_CHK_TIMEOUT_EN to build the per-channel wait
// counters and the timeout check; undefined, err_timeout is constant 0.
module sprot_protocol_checker #(
  parameter int N_CH     = 4,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 16,
  parameter int CW       = 16,
  localparam int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   sp_valid,
  input  logic [N_CH-1:0]   sp_ready,
  input  logic [N_CH*DW-1:0] sp_data,
  input  logic              err_clr,
  output logic [N_CH-1:0]   err_stable,
  output logic [N_CH-1:0]   err_drop,
  output logic [N_CH-1:0]   err_timeout,
  output logic              err_any,
  output logic [CW-1:0]     err_count,
  output logic [CHW-1:0]    err_first_ch
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} ch_state_t;

  // Per-channel violation events for the current cycle
  logic [N_CH-1:0] ev_stable;
  logic [N_CH-1:0] ev_drop;
  logic [N_CH-1:0] ev_timeout;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_t     state;
    logic [DW-1:0] cap;
    logic          stable_seen;
    logic          v;
    logic          r;
    logic [DW-1:0] d;

    assign v = sp_valid[g];
    assign r = sp_ready[g];
    assign d = sp_data[g*DW +: DW];

    // Data compare applies on every valid cycle in WAIT, including the handshake cycle
    assign ev_stable[g] = (state == S_WAIT) && v && (d != cap) && !stable_seen;
    assign ev_drop[g]   = (state == S_WAIT) && !v;

`ifdef SPROT_CHK_TIMEOUT_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] cnt;
    logic          to_hit;

    // Fires on the single cycle where the saturating counter steps onto MAX_WAIT
    assign to_hit        = (state == S_IDLE) ? (MAX_WAIT == 1) : (cnt == WW'(MAX_WAIT - 1));
    assign ev_timeout[g] = v && !r && to_hit;

    // Wait counter: 1 on capture, saturates at MAX_WAIT, cleared when the transaction ends
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (state == S_IDLE) begin
        cnt <= (v && !r) ? WW'(1) : '0;
      end else if (!v || r) begin
        cnt <= '0;
      end else if (cnt != WW'(MAX_WAIT)) begin
        cnt <= cnt + 1'b1;
      end
    end
`else
    assign ev_timeout[g] = 1'b0;
`endif

    // Channel FSM: capture data on a stall, return to IDLE on handshake or drop
    always_ff @(posedge clk) begin
      if (rst) begin
        state       <= S_IDLE;
        cap         <= '0;
        stable_seen <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (v && !r) begin
              state       <= S_WAIT;
              cap         <= d;
              stable_seen <= 1'b0;
            end
          end
          S_WAIT: begin
            if (ev_stable[g]) stable_seen <= 1'b1;
            if (!v || r) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic [N_CH-1:0] ev_any_ch;
  assign ev_any_ch = ev_stable | ev_drop | ev_timeout;

  localparam int SW = $clog2(3 * N_CH + 1);
  localparam int AW = ((CW > SW) ? CW : SW) + 1;

  logic [SW-1:0] ev_num;
  logic [CHW-1:0] ev_low;

  // Number of violation events this cycle across all channels and types
  always_comb begin
    ev_num = '0;
    for (int i = 0; i < N_CH; i++) begin
      ev_num = ev_num + SW'(ev_stable[i]) + SW'(ev_drop[i]) + SW'(ev_timeout[i]);
    end
  end

  // Lowest-index channel with any event this cycle
  always_comb begin
    ev_low = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ev_any_ch[i]) ev_low = CHW'(i);
    end
  end

  // Clear is applied first, then this cycle's events are added on top
  logic [CW-1:0] count_base;
  logic [AW-1:0] count_sum;
  logic [CW-1:0] count_next;
  logic          flags_base_any;

  assign count_base     = err_clr ? '0 : err_count;
  assign count_sum      = AW'(count_base) + AW'(ev_num);
  assign count_next     = (count_sum > AW'({CW{1'b1}})) ? {CW{1'b1}} : count_sum[CW-1:0];
  assign flags_base_any = !err_clr && (|{err_stable, err_drop, err_timeout});

  // Sticky flags, saturating count, first-channel latch and registered err_any
  always_ff @(posedge clk) begin
    if (rst) begin
      err_stable   <= '0;
      err_drop     <= '0;
      err_timeout  <= '0;
      err_any      <= 1'b0;
      err_count    <= '0;
      err_first_ch <= '0;
    end else begin
      err_stable  <= (err_clr ? '0 : err_stable)  | ev_stable;
      err_drop    <= (err_clr ? '0 : err_drop)    | ev_drop;
      err_timeout <= (err_clr ? '0 : err_timeout) | ev_timeout;
      err_any     <= |{err_stable, err_drop, err_timeout};
      err_count   <= count_next;
      if (!flags_base_any && (|ev_any_ch)) begin
        err_first_ch <= ev_low;
      end else if (err_clr) begin
        err_first_ch <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprot_protocol_checker.sv
// tb/tb_sprot_protocol_checker.sv - self-checking bench for sprot_protocol_checker
module tb_sprot_protocol_checker;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            err_clr = 1'b0;
  logic [N-1:0]    sp_valid = '0;
  logic [N-1:0]    sp_ready = '0;
  logic [N*DW-1:0] sp_data = '0;

  logic [N-1:0] a_stable, a_drop, a_to;
  logic         a_any;
  logic [15:0]  a_cnt;
  logic [1:0]   a_first;
  logic [N-1:0] b_stable, b_drop, b_to;
  logic         b_any;
  logic [1:0]   b_cnt;
  logic [1:0]   b_first;

  sprot_protocol_checker dut (
    .clk(clk), .rst(rst), .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_data(sp_data),
    .err_clr(err_clr), .err_stable(a_stable), .err_drop(a_drop), .err_timeout(a_to),
    .err_any(a_any), .err_count(a_cnt), .err_first_ch(a_first)
  );

  sprot_protocol_checker #(.CW(2)) dut_c2 (
    .clk(clk), .rst(rst), .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_data(sp_data),
    .err_clr(err_clr), .err_stable(b_stable), .err_drop(b_drop), .err_timeout(b_to),
    .err_any(b_any), .err_count(b_cnt), .err_first_ch(b_first)
  );

  int vectors = 0;
  int miscompares = 0;
  bit timeout_en = 1'b0;

  // Reference model: transaction-level view of each channel
  bit            m_wait [N];
  logic [DW-1:0] m_cap  [N];
  int            m_len  [N];
  bit            m_sdone[N];
  bit            m_tdone[N];
  logic [N-1:0]  m_stable = '0, m_drop = '0, m_to = '0;
  bit            m_any = 1'b0;
  int            m_cnt16 = 0, m_cnt2 = 0, m_first = 0;

  task automatic model_step();
    logic [N-1:0]  es, ed, et;
    logic [DW-1:0] d;
    int            nev;
    bit            had;
    es = '0; ed = '0; et = '0;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_wait[c] = 0; m_cap[c] = '0; m_len[c] = 0; m_sdone[c] = 0; m_tdone[c] = 0;
      end
      m_stable = '0; m_drop = '0; m_to = '0; m_any = 0;
      m_cnt16 = 0; m_cnt2 = 0; m_first = 0;
      return;
    end
    for (int c = 0; c < N; c++) begin
      d = sp_data[c*DW +: DW];
      if (!m_wait[c]) begin
        if (sp_valid[c] && !sp_ready[c]) begin
          m_wait[c] = 1; m_cap[c] = d; m_len[c] = 1; m_sdone[c] = 0; m_tdone[c] = 0;
        end
      end else if (!sp_valid[c]) begin
        ed[c] = 1'b1; m_wait[c] = 0; m_len[c] = 0;
      end else begin
        if (d !== m_cap[c] && !m_sdone[c]) begin es[c] = 1'b1; m_sdone[c] = 1; end
        if (sp_ready[c]) m_wait[c] = 0;
        else if (m_len[c] < MW) m_len[c]++;
      end
      if (timeout_en && m_wait[c] && m_len[c] == MW && !m_tdone[c]) begin
        et[c] = 1'b1; m_tdone[c] = 1;
      end
    end
    m_any = |{m_stable, m_drop, m_to};
    if (err_clr) begin
      m_stable = '0; m_drop = '0; m_to = '0; m_cnt16 = 0; m_cnt2 = 0; m_first = 0;
    end
    had = |{m_stable, m_drop, m_to};
    nev = $countones(es) + $countones(ed) + $countones(et);
    if (!had) begin
      for (int c = N - 1; c >= 0; c--) if (es[c] | ed[c] | et[c]) m_first = c;
    end
    m_stable |= es; m_drop |= ed; m_to |= et;
    m_cnt16 = (m_cnt16 + nev > 65535) ? 65535 : m_cnt16 + nev;
    m_cnt2  = (m_cnt2 + nev > 3) ? 3 : m_cnt2 + nev;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    sp_valid = '0; sp_ready = '0; sp_data = '0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sp_valid = 4'hF; sp_ready = 4'h0; sp_data = {$urandom, $urandom, $urandom, $urandom};
    step();
    step();
    if ({a_stable, a_drop, a_to, a_any, a_cnt, a_first} !== 31'd0) begin
      miscompares++;
      $display("FAIL reset_a: got %h want 0", {a_stable, a_drop, a_to, a_any, a_cnt, a_first});
    end
    vectors++;
    if ({b_stable, b_drop, b_to, b_any, b_cnt, b_first} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_b: got %h want 0", {b_stable, b_drop, b_to, b_any, b_cnt, b_first});
    end
    vectors++;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_hold_ok();
    do_reset();
    sp_valid = 4'b0001; sp_data[7:0] = 8'hA5;
    for (int i = 0; i < 3; i++) step();
    sp_ready = 4'b0001;
    step();
    idle_inputs();
    step();
    step();
    if ({a_stable, a_drop, a_to, a_any} !== 13'd0) begin
      miscompares++;
      $display("FAIL hold_flags: got %h want 0", {a_stable, a_drop, a_to, a_any});
    end
    vectors++;
    if (a_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL hold_count: got %0d want 0", a_cnt);
    end
    vectors++;
  endtask

  task automatic test_stable();
    do_reset();
    sp_valid = 4'b0010; sp_data[DW +: DW] = 32'h10;
    step();
    sp_data[DW +: DW] = 32'h11;
    step();
    if (a_stable !== 4'b0010 || a_cnt !== 16'd1 || a_first !== 2'd1 || a_any !== 1'b0) begin
      miscompares++;
      $display("FAIL stable_first: got st=%b cnt=%0d first=%0d any=%b want 0010/1/1/0",
               a_stable, a_cnt, a_first, a_any);
    end
    vectors++;
    step();
    if (a_any !== 1'b1 || a_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL stable_any: got any=%b cnt=%0d want 1/1", a_any, a_cnt);
    end
    vectors++;
    sp_data[DW +: DW] = 32'h12;
    step();
    sp_ready = 4'b0010;
    step();
    idle_inputs();
    step();
    if (a_cnt !== 16'd1 || a_drop !== 4'b0000) begin
      miscompares++;
      $display("FAIL stable_once: got cnt=%0d drop=%b want 1/0000", a_cnt, a_drop);
    end
    vectors++;
  endtask

  task automatic test_timeout();
    logic [3:0] want_to;
    logic [15:0] want_cnt;
    want_to  = timeout_en ? 4'b0100 : 4'b0000;
    want_cnt = timeout_en ? 16'd1 : 16'd0;
    do_reset();
    sp_valid = 4'b0100; sp_data[2*DW +: DW] = 32'hCAFE;
    for (int i = 0; i < MW - 1; i++) step();
    if (a_to !== 4'b0000 || a_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL timeout_early: got to=%b cnt=%0d want 0000/0", a_to, a_cnt);
    end
    vectors++;
    step();
    if (a_to !== want_to || a_cnt !== want_cnt) begin
      miscompares++;
      $display("FAIL timeout_hit: got to=%b cnt=%0d want %b/%0d", a_to, a_cnt, want_to, want_cnt);
    end
    vectors++;
    for (int i = 0; i < 5; i++) step();
    sp_ready = 4'b0100;
    step();
    idle_inputs();
    step();
    if (a_to !== want_to || a_cnt !== want_cnt || a_drop !== 4'b0000) begin
      miscompares++;
      $display("FAIL timeout_once: got to=%b cnt=%0d drop=%b want %b/%0d/0000",
               a_to, a_cnt, a_drop, want_to, want_cnt);
    end
    vectors++;
  endtask

  task automatic test_dual_drop();
    do_reset();
    sp_valid = 4'b1001;
    step();
    sp_valid = 4'b0000;
    step();
    if (a_drop !== 4'b1001 || a_cnt !== 16'd2 || a_first !== 2'd0) begin
      miscompares++;
      $display("FAIL dual_drop: got drop=%b cnt=%0d first=%0d want 1001/2/0", a_drop, a_cnt, a_first);
    end
    vectors++;
  endtask

  task automatic test_saturate_clr();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sp_valid = 4'b0001;
      step();
      sp_valid = 4'b0000;
      step();
    end
    if (b_cnt !== 2'd3 || a_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL saturate: got cw2=%0d cw16=%0d want 3/4", b_cnt, a_cnt);
    end
    vectors++;
    sp_valid = 4'b0010;
    step();
    sp_valid = 4'b0000;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    if (b_cnt !== 2'd1 || a_cnt !== 16'd1 || a_drop !== 4'b0010 || b_drop !== 4'b0010 || a_first !== 2'd1) begin
      miscompares++;
      $display("FAIL clr_with_drop: got cnt=%0d/%0d drop=%b/%b first=%0d want 1/1/0010/0010/1",
               b_cnt, a_cnt, a_drop, b_drop, a_first);
    end
    vectors++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    sp_valid = 4'b0001;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sp_valid = 4'b0000;
    step();
    step();
    if ({a_stable, a_drop, a_to, a_any, a_cnt, a_first} !== 31'd0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got %h want 0", {a_stable, a_drop, a_to, a_any, a_cnt, a_first});
    end
    vectors++;
  endtask

  task automatic test_random();
    logic [DW-1:0] dat [N];
    int rmode;
    logic [30:0] exp_a;
    logic [16:0] exp_b;
    do_reset();
    for (int c = 0; c < N; c++) dat[c] = $urandom;
    rmode = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) rmode = $urandom_range(0, 2);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) == 0) dat[c] = $urandom_range(0, 3);
        sp_data[c*DW +: DW] = dat[c];
        sp_valid[c] = ($urandom_range(0, 15) != 0);
        case (rmode)
          0:       sp_ready[c] = ($urandom_range(0, 1) == 0);
          1:       sp_ready[c] = ($urandom_range(0, 7) == 0);
          default: sp_ready[c] = ($urandom_range(0, 31) == 0);
        endcase
      end
      err_clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
      exp_a = {m_stable, m_drop, m_to, m_any, 16'(m_cnt16), 2'(m_first)};
      exp_b = {m_stable, m_drop, m_to, m_any, 2'(m_cnt2), 2'(m_first)};
      if ({a_stable, a_drop, a_to, a_any, a_cnt, a_first} !== exp_a) begin
        miscompares++;
        $display("FAIL random_a cyc %0d: got %h want %h", cyc,
                 {a_stable, a_drop, a_to, a_any, a_cnt, a_first}, exp_a);
      end
      vectors++;
      if ({b_stable, b_drop, b_to, b_any, b_cnt, b_first} !== exp_b) begin
        miscompares++;
        $display("FAIL random_b cyc %0d: got %h want %h", cyc,
                 {b_stable, b_drop, b_to, b_any, b_cnt, b_first}, exp_b);
      end
      vectors++;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
`ifdef SPROT_CHK_TIMEOUT_EN
    timeout_en = 1'b1;
`else
    timeout_en = 1'b0;
`endif
    test_reset();
    test_hold_ok();
    test_stable();
    test_timeout();
    test_dual_drop();
    test_saturate_clr();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprot_protocol_checker.md
SPROT_PROTOCOL_CHECKER -- requirements
Module: sprot_protocol_checker

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent sprot channels monitored.
REQ-002 SHALL have parameter DW, default 32: per-channel data width.
REQ-003 SHALL have parameter MAX_WAIT, default 16: valid-without-ready cycles allowed before timeout; legal range 1..65535.
REQ-004 SHALL have parameter CW, default 16: error counter width.
REQ-005 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port sp_valid  input  N_CH: per-channel valid, bit i = channel i.
REQ-008 SHALL have port sp_ready  input  N_CH: per-channel ready.
REQ-009 SHALL have port sp_data  input  N_CH*DW: channel i data at bits [i*DW +: DW].
REQ-010 SHALL have port err_clr  input  1: one-cycle pulse clearing all error state.
REQ-011 SHALL have port err_stable  output  N_CH: sticky, data changed while valid held without ready.
REQ-012 SHALL have port err_drop  output  N_CH: sticky, valid deasserted before ready.
REQ-013 SHALL have port err_timeout  output  N_CH: sticky, wait reached MAX_WAIT cycles.
REQ-014 SHALL have port err_any  output  1: OR of all sticky flags, registered.
REQ-015 SHALL have port err_count  output  CW: total violation events since reset or clear, saturating.
REQ-016 SHALL have port err_first_ch  output  max(1,$clog2(N_CH)): channel of first violation since reset or clear.

Function
REQ-017 Each channel SHALL run a two-state FSM, IDLE and WAIT, with a captured-data register and a wait counter.
REQ-018 IDLE, valid&&ready: handshake, stay IDLE. IDLE, valid&&!ready: capture sp_data, counter=1, go WAIT. Otherwise stay IDLE.
REQ-019 WAIT, valid&&ready: go IDLE; data still compared this cycle.
REQ-020 WAIT, valid&&!ready: compare data, increment counter saturating at MAX_WAIT, stay WAIT.
REQ-021 WAIT, !valid: drop violation, go IDLE, counter=0.
REQ-022 Data mismatch in WAIT SHALL be a stable violation once per transaction; further mismatches in the same transaction SHALL NOT count again.
REQ-023 Counter reaching MAX_WAIT SHALL be a timeout violation exactly once per transaction; channel stays WAIT until handshake or drop.
REQ-024 A violation sampled at edge k SHALL appear on flags, err_count and err_first_ch after edge k (one-cycle latency); err_any SHALL follow one cycle after the flags.
REQ-025 err_count SHALL add the number of violation events in the cycle (all channels, all types, up to 3*N_CH) and saturate at 2^CW-1 without wrap.
REQ-026 err_first_ch SHALL latch only while no flag is set; on simultaneous first violations the lowest channel index SHALL win.
REQ-027 err_clr together with new violations: clear applies first, then the new events set flags, count and first-channel; new events win.
REQ-028 err_clr SHALL NOT affect channel FSMs, captured data or wait counters.
REQ-029 Block SHALL be monitor-only: no output drives the sprot bus; combinational depth independent of N_CH except the count adder.

Reset
REQ-030 While rst is high at an edge, all FSMs SHALL go IDLE and counters, flags, err_any, err_count and err_first_ch SHALL be 0.
REQ-031 Reset during WAIT SHALL abandon the transaction with no violation; the first post-reset cycle is treated as IDLE.

Configuration
REQ-032 Macro SPROT_CHK_TIMEOUT_EN defined: wait counters and timeout check per REQ-023 present.
REQ-033 Macro SPROT_CHK_TIMEOUT_EN undefined: counters and timeout check removed, err_timeout tied to 0, MAX_WAIT ignored; all other behaviour unchanged.

Verification
REQ-034 Ch0 valid=1, ready=0, data 0xA5 for 3 cycles, then ready=1 -> no flags, err_count=0.
REQ-035 Ch1 valid with data 0x10, then 0x11 next cycle, ready=0 -> err_stable[1]=1, err_count=1, err_first_ch=1, err_any=1 one cycle later.
REQ-036 Ch2 valid=1, ready=0 for 16 cycles (MAX_WAIT=16, macro defined) -> err_timeout[2] set once, err_count=1; same stimulus without macro -> err_timeout=0, err_count=0.
REQ-037 Ch0 and ch3 drop valid in the same cycle while WAIT -> err_drop=4'b1001, err_count=2, err_first_ch=0.
REQ-038 CW=2, four consecutive drop violations -> err_count stays 3; err_clr coincident with a ch1 drop -> err_count=1, err_drop=4'b0010, err_first_ch=1.
REQ-039 rst asserted mid-WAIT on ch0 with valid dropping the next cycle -> no err_drop, all outputs 0.
